// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, legal-op limit and datapath width.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    AND = 4'b0010,
    OR  = 4'b0011,
    XOR = 4'b0100
  } alu_op_e;

  localparam logic [3:0] ALU_OP_MAX = 4'b0100;

  function automatic logic op_illegal(input logic [3:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Search upward from the pointer, wrapping past N-1 back to 0.
  always_comb begin
    int cand;
    found_s = 1'b0;
    idx_s   = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_r) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (!found_s && req[IW'(cand)]) begin
        found_s = 1'b1;
        idx_s   = IW'(cand);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant, suppressed when issuing is disabled.
  always_comb begin
    gnt     = '0;
    gnt_idx = idx_s;
    if (en && found_s) begin
      gnt[idx_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Pointer update on accepted grant only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (int'(idx_s) == N - 1) ? '0 : idx_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 16-bit ALU among NUM_REQ requesters; the winner's operands drive
// the ALU and the result lands in a one-entry response buffer.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TAG_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]      req_ctrl,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [3:0]                alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err
);

  logic               can_issue_s;
  logic               accept_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic [ID_W-1:0]    sel_s;
  logic [3:0]         sel_ctrl_s;
  logic [TAG_W-1:0]   sel_tag_s;

  // rst_n gates issue so no requester sees ready while reset is held.
  assign can_issue_s = rst_n && (!rsp_valid || rsp_ready);
  assign accept_s    = |gnt_s;
  assign req_ready   = gnt_s;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (can_issue_s),
    .advance (accept_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Idle cycles park the ALU on requester 0 with a harmless ADD op.
  always_comb begin
    sel_s = '0;
    if (accept_s) begin
      sel_s = gnt_idx_s;
    end else begin
      sel_s = '0;
    end
    alu_a      = req_a[int'(sel_s)*DATA_W +: DATA_W];
    alu_b      = req_b[int'(sel_s)*DATA_W +: DATA_W];
    sel_ctrl_s = req_ctrl[int'(sel_s)*4 +: 4];
    sel_tag_s  = req_tag[int'(sel_s)*TAG_W +: TAG_W];
    if (accept_s) begin
      alu_ctrl = sel_ctrl_s;
    end else begin
      alu_ctrl = ADD;
    end
  end

  // Response buffer: load on accept, clear valid on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept_s) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_idx_s;
      rsp_tag    <= sel_tag_s;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_err    <= op_illegal(sel_ctrl_s);
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid  <= rsp_valid;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the shared port.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] req_ctrl;
  logic [15:0] req_tag;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_tag;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NUM_REQ(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: illegal op codes return 0.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] c, input logic [3:0] t);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_ctrl[i*4 +: 4] = c;
    req_tag[i*4 +: 4] = t;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a = 64'h0; req_b = 64'h0; req_ctrl = 16'h0; req_tag = 16'h0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h exp 0", rsp_tag); end
    checks++; if (rsp_result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", rsp_result); end
    checks++; if (rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_flags got zero=%b err=%b exp 0 0", rsp_zero, rsp_err); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    @(negedge clk);
    req_valid = 4'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(2, 16'h0003, 16'h0005, ADD, 4'hA);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    checks++; if (alu_a !== 16'h0003 || alu_b !== 16'h0005) begin errors++; $display("FAIL single_operands got %h %h exp 0003 0005", alu_a, alu_b); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_result !== 16'h0008) begin errors++; $display("FAIL single_result got %h exp 0008", rsp_result); end
    checks++; if (rsp_id !== 2'd2 || rsp_tag !== 4'hA) begin errors++; $display("FAIL single_idtag got %0d %h exp 2 a", rsp_id, rsp_tag); end
    checks++; if (rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_flags got %b %b exp 0 0", rsp_zero, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'(i * 16), 16'h0001, ADD, 4'(i + 1));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      #1;
      checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << e)); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e)) begin errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d exp v=1 id=%0d", k, rsp_valid, rsp_id, e); end
      checks++; if (rsp_result !== 16'(e * 16 + 1) || rsp_tag !== 4'(e + 1)) begin errors++; $display("FAIL rr_data[%0d] got %h %h exp %h %h", k, rsp_result, rsp_tag, 16'(e * 16 + 1), 4'(e + 1)); end
      @(negedge clk);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_back_pressure();
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'(i * 16), 16'h0001, ADD, 4'(i + 1));
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready got %b exp 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd0 || rsp_result !== 16'h0001) begin errors++; $display("FAIL bp_first_rsp got %0d %h exp 0 0001", rsp_id, rsp_result); end
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b exp 0000", k, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'h0001 || rsp_tag !== 4'h1) begin
        errors++; $display("FAIL bp_frozen[%0d] got v=%b id=%0d r=%h t=%h exp 1 0 0001 1", k, rsp_valid, rsp_id, rsp_result, rsp_tag);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume_ready got %b exp 0010", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd1 || rsp_result !== 16'h0011) begin errors++; $display("FAIL bp_resume_rsp got %0d %h exp 1 0011", rsp_id, rsp_result); end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_drain();
    set_req(0, 16'hBEEF, 16'h0001, SUB, 4'h3);
    req_valid = 4'h0;
    #1;
    checks++; if (alu_a !== 16'hBEEF || alu_ctrl !== 4'b0000) begin errors++; $display("FAIL idle_drive got %h %b exp beef 0000", alu_a, alu_ctrl); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 16'h0011 || rsp_id !== 2'd1) begin errors++; $display("FAIL drain got v=%b r=%h id=%0d exp 0 0011 1", rsp_valid, rsp_result, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_zero_wrap();
    set_req(1, 16'h1234, 16'h1234, SUB, 4'h5);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    checks++; if (rsp_result !== 16'h0000 || rsp_zero !== 1'b1 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL sub_zero got r=%h z=%b id=%0d e=%b exp 0000 1 1 0", rsp_result, rsp_zero, rsp_id, rsp_err);
    end
    @(negedge clk);
    set_req(3, 16'hFFFF, 16'h0001, ADD, 4'h6);
    req_valid = 4'b1000;
    @(posedge clk); #1;
    checks++; if (rsp_result !== 16'h0000 || rsp_zero !== 1'b1 || rsp_id !== 2'd3 || rsp_tag !== 4'h6) begin
      errors++; $display("FAIL add_wrap got r=%h z=%b id=%0d t=%h exp 0000 1 3 6", rsp_result, rsp_zero, rsp_id, rsp_tag);
    end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_illegal();
    set_req(0, 16'h5555, 16'h00FF, 4'b1010, 4'h7);
    req_valid = 4'b0001;
    #1;
    checks++; if (alu_ctrl !== 4'b1010) begin errors++; $display("FAIL illegal_drive got %b exp 1010", alu_ctrl); end
    @(posedge clk); #1;
    checks++; if (rsp_result !== 16'h0000 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL illegal_rsp got r=%h z=%b e=%b exp 0000 1 1", rsp_result, rsp_zero, rsp_err);
    end
    @(negedge clk);
    set_req(0, 16'h00F0, 16'h0F00, OR, 4'h8);
    @(posedge clk); #1;
    checks++; if (rsp_result !== 16'h0FF0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL legal_after got r=%h z=%b e=%b exp 0ff0 0 0", rsp_result, rsp_zero, rsp_err);
    end
    @(negedge clk);
    set_req(0, 16'h0000, 16'h0000, XOR, 4'h9);
    set_req(2, 16'h0100, 16'h0011, 4'b0101, 4'hB);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    checks++; if (rsp_err !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL illegal_0101 got e=%b id=%0d exp 1 2", rsp_err, rsp_id); end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_req(2, 16'h0003, 16'h0005, ADD, 4'hA);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h0008) begin errors++; $display("FAIL ar_pre got v=%b r=%h exp 1 0008", rsp_valid, rsp_result); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL ar_drop got v=%b r=%h id=%0d exp 0 0000 0", rsp_valid, rsp_result, rsp_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_grant got %b exp 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL ar_first_rsp got %0d exp 0", rsp_id); end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_drain();
    test_zero_wrap();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 16-bit integer ALU among NUM_REQ requesters, e.g. the EX stage, the address-generation unit and the debug/scan port.
- Arbitrates round-robin with a valid/ready handshake per requester.
- Drives the ALU operand and control lines combinationally and registers the ALU result into a one-entry response buffer.
- The response carries the winner's ID and tag back to the requesters.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TAG_W, 4: width of the opaque per-request tag returned with the result.
- ID_W, $clog2(NUM_REQ): width of the requester index (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*16  packed operand A, requester i at bits [16i+15:16i].
- req_b  in  NUM_REQ*16  packed operand B.
- req_ctrl  in  NUM_REQ*4  packed ALU op code.
- req_tag  in  NUM_REQ*TAG_W  packed tag.
- alu_a  out  16  operand A to the ALU.
- alu_b  out  16  operand B to the ALU.
- alu_ctrl  out  4  op code to the ALU.
- alu_result  in  16  ALU result (combinational return).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that produced the response.
- rsp_tag  out  TAG_W  tag of that request.
- rsp_result  out  16  registered result.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  op code was outside the legal set 0000..0100.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rsp_valid=0; rsp_id=0; rsp_tag=0; rsp_result=0; rsp_zero=0; rsp_err=0.
  - Round-robin pointer = 0; req_ready=0 while in reset.
- can_issue = !rsp_valid || rsp_ready. The buffer may be refilled in the same cycle it drains.
- Grant (combinational):
  - If can_issue and any req_valid, the winner is the first set req_valid at or after the pointer, searching upward and wrapping from NUM_REQ-1 to 0.
  - req_ready[winner]=1; all other bits 0. If !can_issue, req_ready is all 0.
- ALU drive:
  - alu_a, alu_b and alu_ctrl carry the winner's fields.
  - With no winner, they carry requester 0's fields with alu_ctrl forced to 0000, so the ALU does not toggle needlessly.
- Accept: req_valid[i] && req_ready[i]. On the next edge:
  - rsp_result<=alu_result; rsp_zero<=alu_zero.
  - rsp_id<=i; rsp_tag<=req_tag[i].
  - rsp_err<=(req_ctrl[i] > 4'b0100); rsp_valid<=1.
  - Pointer <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept to rsp_valid. Throughput is 1 op per cycle when rsp_ready is held high.
- Drain without new accept: rsp_valid<=0; the data fields hold their last value.
- Stall (rsp_valid && !rsp_ready): the response fields are frozen, no grant is issued, and the pointer is held.
- Pointer changes only on accept. It is not advanced by idle cycles or by requesters that are not valid.
- Requester obligations (assertion targets, not checked by RTL):
  - Once req_valid is asserted, it stays high with stable fields until accepted.
  - Dropping req_valid before accept is illegal.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…. Maximum wait is NUM_REQ-1 accepts.
- Illegal op codes are still issued; the ALU returns 0, rsp_zero=1 and rsp_err=1.
- Reset asserted mid-operation discards the buffered response immediately. No partial state survives.

Decomposition:
- Shared package alu_pkg:
  - ALU op enum: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100.
  - Constant ALU_OP_MAX=4'b0100.
  - DATA_W=16.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], en, advance, clk, rst_n.
  - Outputs: one-hot gnt[N] and gnt_idx.
  - Owns the pointer; reused later by the register-file port arbiter.
- The top level holds the muxing, the response buffer and the error decode.

Test Plan:
- Single request: reset, then req 2 valid with a=16'h0003, b=16'h0005, ctrl=ADD, tag=4'hA → req_ready[2] same cycle; next cycle rsp_valid=1, rsp_result=16'h0008, rsp_id=2, rsp_tag=4'hA, rsp_zero=0, rsp_err=0.
- Round-robin: all 4 valid continuously with rsp_ready=1 → grant order 0,1,2,3,0 on consecutive cycles and 5 back-to-back responses.
- Back-pressure: rsp_ready=0 for 3 cycles after the first response → req_ready all 0 for those cycles, rsp_* frozen; on rsp_ready=1, the next grant occurs in the same cycle.
- Zero and wrap: SUB with a=b=16'h1234 → rsp_result=0, rsp_zero=1. ADD with 16'hFFFF+16'h0001 → result 16'h0000, rsp_zero=1.
- Illegal op: ctrl=4'b1010 → rsp_result=0, rsp_zero=1, rsp_err=1; the next legal op clears rsp_err.
- Async reset: assert rst_n low mid-cycle while rsp_valid=1 → rsp_valid drops without waiting for a clock edge; after release, the first grant goes to requester 0 when all are valid.
